mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the RISC-V RV32I subset: lw, sw, R-type ALU, I-type ALU, beq and jal. It sequences the shared single-ALU, single-memory datapath through a Moore state machine and decodes ALUControl internally. It also drives the immediate-select code and the PC, IR, register-file and memory write strobes. It sits between the instruction register and the multicycle datapath and stalls on a memory-ready handshake.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- op  input  7  instruction opcode, from the IR
- funct3  input  3  instruction funct3
- funct7b5  input  1  instruction bit 30
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  data memory write strobe
- ir_write  output  1  IR and OldPC enable
- result_src  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- alu_src_b  output  2  ALU B select: 00 rs2, 01 ImmExt, 10 constant 4
- imm_src  output  2  immediate format select
- alu_control  output  3  ALU operation code
- reg_write  output  1  register-file write enable
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state_o  output  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 go to FETCH.
- Transitions:
  - FETCH goes to DECODE only when mem_ready=1; otherwise it holds.
  - DECODE branches on op:
    - 0000011 or 0100011 goes to MEMADR.
    - 0110011 goes to EXECR.
    - 0010011 goes to EXECI.
    - 1100011 goes to BEQ.
    - 1101111 goes to JAL.
    - Any other op goes to FETCH and registers illegal_op=1 for one cycle.
  - MEMADR goes to MEMREAD when op=0000011, else to MEMWRITE.
  - MEMREAD goes to MEMWB when mem_ready=1; otherwise it holds.
  - MEMWRITE goes to FETCH when mem_ready=1; otherwise it holds.
  - EXECR and EXECI go to ALUWB. JAL goes to ALUWB.
  - MEMWB, ALUWB and BEQ go to FETCH.
- Moore outputs per state. Any signal not listed is 0.
  - FETCH: ALUSrcB=10, ResultSrc=10, ALUOp=00. ir_write and pc_update are both gated by mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: adr_src=1.
  - MEMWRITE: adr_src=1; mem_write=1 every cycle the state is held.
  - MEMWB: ResultSrc=01, reg_write=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: reg_write=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, pc_update=1.
- pc_write = pc_update | (branch & taken). Without the configuration macro, taken = zero.
- imm_src is combinational from op:
  - 0100011 gives 01.
  - 1100011 gives 10.
  - 1101111 gives 11.
  - Any other op gives 00.
- alu_control by ALUOp:
  - ALUOp 00 gives 000 (add).
  - ALUOp 01 gives 001 (sub).
  - ALUOp 10 decodes funct3:
    - funct3 000 gives 001 when op[5]&funct7b5, else 000.
    - funct3 010 gives 101 (slt).
    - funct3 110 gives 011 (or).
    - funct3 111 gives 010 (and).
    - Any other funct3 gives 000.

## Timing
- Reset: when reset=0 at a rising edge, the state becomes FETCH and illegal_op becomes 0.
- While reset=0, pc_write, ir_write, mem_write and reg_write are forced to 0 combinationally. All other outputs take their FETCH values.
- Reset asserted mid-instruction aborts the instruction. No write strobe fires after that edge.
- Instruction latencies with mem_ready held high:
  - beq: 3 cycles.
  - R-type, I-type, jal, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- A stall in FETCH never double-increments the PC: pc_write is asserted only in the cycle where mem_ready=1.
- All outputs except illegal_op are combinational from the state register and the inputs. illegal_op and state_o are registered.

## Configuration
- MC_CONTROLLER_BNE_EN defined: in BEQ, taken = funct3[0] ? ~zero : zero. This adds bne (funct3=001).
- MC_CONTROLLER_BNE_EN undefined: taken = zero and funct3 is ignored in BEQ.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release. Required: state_o=0 and all four strobes stay 0 during reset. ir_write=1 and pc_write=1 in the first cycle after release with mem_ready=1.
- lw (op=0000011) with mem_ready=1: state_o sequence 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. adr_src=1 in state 3.
- R-type sub (op=0110011, funct3=000, funct7b5=1): alu_control=001 in EXECR. With funct7b5=0, alu_control=000. funct3=111 gives 010.
- FETCH stall: hold mem_ready=0 for 3 cycles. Required: state_o stays 0 and pc_write=0 during the stall. Exactly one pc_write pulse occurs when mem_ready=1.
- beq (op=1100011): zero=1 gives pc_write=1 in state 9. zero=0 gives pc_write=0. With MC_CONTROLLER_BNE_EN defined, funct3=001 and zero=0 gives pc_write=1.
- op=1111111 in DECODE: next state 0 and illegal_op=1 for exactly one cycle.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore sequencer plus ALU/immediate decode.
// Optional macro MC_CONTROLLER_BNE_EN adds bne by inverting the branch sense on funct3[0].
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       reg_write,
   output logic       illegal_op,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t     r_state;
   state_t     w_next;
   state_t     w_cur;
   logic       r_illegal;
   logic       w_illegal_nxt;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_taken;
   logic       w_ir_write;
   logic       w_mem_write;
   logic       w_reg_write;
   logic [1:0] w_alu_op;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_illegal <= w_illegal_nxt;
      end
   end

   always_comb begin
      w_next        = S_FETCH;
      w_illegal_nxt = 1'b0;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECR;
               OP_I:         w_next = S_EXECI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
               default: begin
                  w_next        = S_FETCH;
                  w_illegal_nxt = 1'b1;
               end
            endcase
         end
         S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // Outputs are decoded from FETCH while reset is held so the datapath sees a clean fetch setup.
   assign w_cur = reset ? r_state : S_FETCH;

   always_comb begin
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      w_alu_op    = 2'b00;
      case (w_cur)
         S_FETCH: begin
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            w_ir_write  = mem_ready;
            w_pc_update = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            w_mem_write = 1'b1;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            w_reg_write = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            w_alu_op  = 2'b10;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            w_alu_op  = 2'b10;
         end
         S_ALUWB:    w_reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = 2'b10;
            w_alu_op  = 2'b01;
            w_branch  = 1'b1;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            w_pc_update = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MC_CONTROLLER_BNE_EN
   assign w_taken = funct3[0] ? ~zero : zero;
`else
   assign w_taken = zero;
`endif

   assign pc_write  = reset & (w_pc_update | (w_branch & w_taken));
   assign ir_write  = reset & w_ir_write;
   assign mem_write = reset & w_mem_write;
   assign reg_write = reset & w_reg_write;

   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   always_comb begin
      alu_control = 3'b000;
      case (w_alu_op)
         2'b01: alu_control = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alu_control = 3'b101;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'b000;
            endcase
         end
         default: alu_control = 3'b000;
      endcase
   end

   assign illegal_op = r_illegal;
   assign state_o    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; expected values worked out by hand from the state table.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_control;
   logic       reg_write;
   logic       illegal_op;
   logic [3:0] state_o;

   int n_checks = 0;
   int n_errors = 0;

   mc_controller dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .imm_src     (imm_src),
      .alu_control (alu_control),
      .reg_write   (reg_write),
      .illegal_op  (illegal_op),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes0(input string tag);
      chk({tag, "_pcw"}, {31'd0, pc_write}, 32'd0);
      chk({tag, "_irw"}, {31'd0, ir_write}, 32'd0);
      chk({tag, "_memw"}, {31'd0, mem_write}, 32'd0);
      chk({tag, "_regw"}, {31'd0, reg_write}, 32'd0);
   endtask

   initial begin
      reset = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
      zero = 1'b0; mem_ready = 1'b1;

      // reset held two cycles with mem_ready high
      step();
      chk("rst1_state", {28'd0, state_o}, 32'd0);
      strobes0("rst1");
      chk("rst1_illegal", {31'd0, illegal_op}, 32'd0);
      step();
      chk("rst2_state", {28'd0, state_o}, 32'd0);
      strobes0("rst2");
      chk("rst2_srcb", {30'd0, alu_src_b}, 32'd2);
      reset = 1'b1;
      #1;
      chk("rel_irw", {31'd0, ir_write}, 32'd1);
      chk("rel_pcw", {31'd0, pc_write}, 32'd1);
      chk("rel_ressrc", {30'd0, result_src}, 32'd2);

      // lw: 0,1,2,3,4,0
      step();
      chk("lw_s1", {28'd0, state_o}, 32'd1);
      chk("lw_dec_srca", {30'd0, alu_src_a}, 32'd1);
      chk("lw_dec_srcb", {30'd0, alu_src_b}, 32'd1);
      chk("lw_dec_regw", {31'd0, reg_write}, 32'd0);
      step();
      chk("lw_s2", {28'd0, state_o}, 32'd2);
      chk("lw_adr_srca", {30'd0, alu_src_a}, 32'd2);
      step();
      chk("lw_s3", {28'd0, state_o}, 32'd3);
      chk("lw_rd_adrsrc", {31'd0, adr_src}, 32'd1);
      chk("lw_rd_regw", {31'd0, reg_write}, 32'd0);
      step();
      chk("lw_s4", {28'd0, state_o}, 32'd4);
      chk("lw_wb_regw", {31'd0, reg_write}, 32'd1);
      chk("lw_wb_ressrc", {30'd0, result_src}, 32'd1);
      step();
      chk("lw_s0", {28'd0, state_o}, 32'd0);

      // R-type: sub/add/and/slt in EXECR
      op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
      step();
      step();
      chk("r_s6", {28'd0, state_o}, 32'd6);
      chk("r_sub", {29'd0, alu_control}, 32'd1);
      chk("r_srcb", {30'd0, alu_src_b}, 32'd0);
      funct7b5 = 1'b0; #1;
      chk("r_add", {29'd0, alu_control}, 32'd0);
      funct3 = 3'b111; #1;
      chk("r_and", {29'd0, alu_control}, 32'd2);
      funct3 = 3'b010; #1;
      chk("r_slt", {29'd0, alu_control}, 32'd5);
      funct3 = 3'b110; #1;
      chk("r_or", {29'd0, alu_control}, 32'd3);
      step();
      chk("r_s8", {28'd0, state_o}, 32'd8);
      chk("r_wb_regw", {31'd0, reg_write}, 32'd1);
      step();
      chk("r_s0", {28'd0, state_o}, 32'd0);

      // addi with funct7b5=1 must stay add (op[5]=0)
      op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
      step();
      step();
      chk("i_s7", {28'd0, state_o}, 32'd7);
      chk("i_add", {29'd0, alu_control}, 32'd0);
      chk("i_srcb", {30'd0, alu_src_b}, 32'd1);
      step();
      step();
      chk("i_s0", {28'd0, state_o}, 32'd0);

      // FETCH stall for 3 cycles, then one pc_write pulse
      op = 7'b1100011; funct7b5 = 1'b0; zero = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_pcw", {31'd0, pc_write}, 32'd0);
         chk("stall_irw", {31'd0, ir_write}, 32'd0);
         step();
         chk("stall_state", {28'd0, state_o}, 32'd0);
      end
      mem_ready = 1'b1; #1;
      chk("stall_rel_pcw", {31'd0, pc_write}, 32'd1);
      step();
      chk("stall_s1", {28'd0, state_o}, 32'd1);
      chk("stall_dec_pcw", {31'd0, pc_write}, 32'd0);
      chk("beq_imm", {30'd0, imm_src}, 32'd2);

      // beq
      step();
      chk("beq_s9", {28'd0, state_o}, 32'd9);
      chk("beq_taken_pcw", {31'd0, pc_write}, 32'd1);
      chk("beq_aluc", {29'd0, alu_control}, 32'd1);
      zero = 1'b0; #1;
      chk("beq_nt_pcw", {31'd0, pc_write}, 32'd0);
      funct3 = 3'b001; #1;
`ifdef MC_CONTROLLER_BNE_EN
      chk("bne_taken_pcw", {31'd0, pc_write}, 32'd1);
      zero = 1'b1; #1;
      chk("bne_nt_pcw", {31'd0, pc_write}, 32'd0);
`else
      chk("f3_ignored_pcw", {31'd0, pc_write}, 32'd0);
      zero = 1'b1; #1;
      chk("f3_ignored_zero_pcw", {31'd0, pc_write}, 32'd1);
`endif
      funct3 = 3'b000; zero = 1'b0;
      step();
      chk("beq_s0", {28'd0, state_o}, 32'd0);

      // sw with one stall cycle in MEMWRITE
      op = 7'b0100011;
      step();
      chk("sw_imm", {30'd0, imm_src}, 32'd1);
      step();
      chk("sw_s2", {28'd0, state_o}, 32'd2);
      step();
      chk("sw_s5", {28'd0, state_o}, 32'd5);
      chk("sw_memw", {31'd0, mem_write}, 32'd1);
      chk("sw_adrsrc", {31'd0, adr_src}, 32'd1);
      mem_ready = 1'b0;
      step();
      chk("sw_hold_s5", {28'd0, state_o}, 32'd5);
      chk("sw_hold_memw", {31'd0, mem_write}, 32'd1);
      mem_ready = 1'b1;
      step();
      chk("sw_s0", {28'd0, state_o}, 32'd0);

      // jal
      op = 7'b1101111;
      step();
      step();
      chk("jal_s10", {28'd0, state_o}, 32'd10);
      chk("jal_pcw", {31'd0, pc_write}, 32'd1);
      chk("jal_srca", {30'd0, alu_src_a}, 32'd1);
      chk("jal_srcb", {30'd0, alu_src_b}, 32'd2);
      chk("jal_imm", {30'd0, imm_src}, 32'd3);
      step();
      chk("jal_s8", {28'd0, state_o}, 32'd8);
      step();
      chk("jal_s0", {28'd0, state_o}, 32'd0);

      // illegal opcode: one-cycle pulse
      op = 7'b1111111;
      step();
      chk("ill_s1", {28'd0, state_o}, 32'd1);
      chk("ill_pre", {31'd0, illegal_op}, 32'd0);
      step();
      chk("ill_s0", {28'd0, state_o}, 32'd0);
      chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
      step();
      chk("ill_s1b", {28'd0, state_o}, 32'd1);
      chk("ill_clear", {31'd0, illegal_op}, 32'd0);
      step();

      // reset in the middle of lw aborts it
      op = 7'b0000011;
      step();
      step();
      chk("abort_s2", {28'd0, state_o}, 32'd2);
      reset = 1'b0; #1;
      strobes0("abort_comb");
      chk("abort_srca", {30'd0, alu_src_a}, 32'd0);
      chk("abort_srcb", {30'd0, alu_src_b}, 32'd2);
      step();
      chk("abort_state", {28'd0, state_o}, 32'd0);
      strobes0("abort_reg");
      reset = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
